switch_debouncer: RTL and testbench

Conditions the four raw DIP-switch inputs before they reach the LED and seven-segment controllers. Each bit passes through a two-flop synchronizer and an independent settle counter. A bit's clean output changes only after its synchronized input has held a new value for a full settle window. The block sits directly upstream of the top-level `s` consumers and replaces the raw switch bus with a glitch-free, clock-domain-safe one.

---
 rtl/lab_pkg.sv | 14 +
 rtl/debounce_bit.sv | 82 ++++++++
 rtl/switch_debouncer.sv | 48 ++++
 tb/tb_switch_debouncer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/lab_pkg.sv
// rtl/lab_pkg.sv - shared types and constants for the switch conditioning path
package lab_pkg;

    // Per-bit debounce FSM states
    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } debounce_state_t;

    // 20 ms settle window at the 24 MHz system clock
    localparam int DEFAULT_SETTLE_CYCLES = 480000;
    localparam int SYS_CLK_HZ            = 24000000;

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - one switch bit: two-flop synchronizer plus settle-window FSM
module debounce_bit
    import lab_pkg::*;
#(
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic s_raw,
    output logic s,
    output logic accept
);

    localparam int CW = $clog2(SETTLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    logic            sync1;
    logic            sync2;
    debounce_state_t state;
    debounce_state_t state_d;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_d;
    logic            take;

    // Next-state logic. The edge that enters PENDING already sees the new
    // level, so it is counted as the first held cycle of the window; the
    // accept then lands SETTLE_CYCLES edges after sync2 first shows the level.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        take    = 1'b0;
        case (state)
            STABLE: begin
                cnt_d = '0;
                if (sync2 != s) begin
                    state_d = PENDING;
                    cnt_d   = CNT_ONE;
                end
            end
            PENDING: begin
                if (sync2 == s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt == CNT_LAST) begin
                    take    = 1'b1;
                    state_d = STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Synchronizer, FSM state, counter and the accepted level; accept flags
    // the edge on which s took a new value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            state  <= STABLE;
            cnt    <= '0;
            s      <= 1'b0;
            accept <= 1'b0;
        end else begin
            sync1  <= s_raw;
            sync2  <= sync1;
            state  <= state_d;
            cnt    <= cnt_d;
            accept <= take;
            if (take) begin
                s <= sync2;
            end
        end
    end

endmodule

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - debounced switch bus; SWITCH_DEBOUNCER_CHANGE_STROBE_EN builds s_changed
module switch_debouncer
    import lab_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_raw,
    output logic [WIDTH-1:0] s,
    output logic             s_changed
);

    if (SETTLE_CYCLES < 2) begin : g_bad_settle
        $error("switch_debouncer: SETTLE_CYCLES must be at least 2");
    end

    logic [WIDTH-1:0] accept;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .SETTLE_CYCLES(SETTLE_CYCLES)
        ) u_bit (
            .clk    (clk),
            .reset  (reset),
            .s_raw  (s_raw[i]),
            .s      (s[i]),
            .accept (accept[i])
        );
    end

`ifdef SWITCH_DEBOUNCER_CHANGE_STROBE_EN
    // One pulse for any set of bits that accepted on the same edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s_changed <= 1'b0;
        end else begin
            s_changed <= |accept;
        end
    end
`else
    logic unused_accept;
    assign unused_accept = |accept;
    assign s_changed     = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - scoreboard bench for switch_debouncer with a 4-cycle settle window
module tb_switch_debouncer;

    localparam int W = 4;
    localparam int S = 4;
`ifdef SWITCH_DEBOUNCER_CHANGE_STROBE_EN
    localparam bit STROBE_EN = 1'b1;
`else
    localparam bit STROBE_EN = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] val;
        int           at;
    } exp_t;

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] s_raw = 4'hF;
    logic [W-1:0] s;
    logic         s_changed;

    int   cyc   = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    exp_t q[$];

    switch_debouncer #(
        .WIDTH         (W),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_raw     (s_raw),
        .s         (s),
        .s_changed (s_changed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic expect_update(input logic [W-1:0] v, input int at);
        exp_t e;
        e.val = v;
        e.at  = at;
        q.push_back(e);
    endtask

    // Drive a new level captured at edge k; s must still be old at edge k+S
    // and take the new level at edge k+1+S.
    task automatic step(input string name, input logic [W-1:0] nv, input logic [W-1:0] old_s);
        int k;
        s_raw = nv;
        k = cyc + 1;
        expect_update(nv, k + 1 + S);
        tick(S + 1);
        check({name, " before window"}, s, old_s);
        tick(1);
        check({name, " after window"}, s, nv);
        tick(6);
    endtask

    // Monitor: every change of s pops the scoreboard; s_changed must follow
    // one cycle after each update (or stay 0 in the strobe-less build).
    initial begin
        logic [W-1:0] prev_s;
        bit           upd;
        exp_t         e;
        prev_s = '0;
        upd    = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_s = s;
                upd    = 1'b0;
            end else begin
                check("s_changed", s_changed, STROBE_EN && upd);
                if (s !== prev_s) begin
                    if (q.size() == 0) begin
                        check("unexpected s update", s, prev_s);
                    end else begin
                        e = q.pop_front();
                        check("s value", s, e.val);
                        check("s update edge", cyc, e.at);
                    end
                    upd = 1'b1;
                end else begin
                    upd = 1'b0;
                end
                prev_s = s;
            end
        end
    end

    initial begin
        int k;

        // Reset held with all switches high
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("reset s", s, 4'h0);
            check("reset s_changed", s_changed, 1'b0);
        end
        reset = 1'b1;
        k = cyc + 1;
        expect_update(4'hF, k + 1 + S);
        tick(S + 1);
        check("release before window", s, 4'h0);
        tick(1);
        check("release after window", s, 4'hF);
        tick(6);

        // Clean steps
        step("clear", 4'h0, 4'hF);
        step("clean step", 4'h5, 4'h0);
        step("bit0 low", 4'h4, 4'h5);

        // Bounce on bit0: 1,0 for two cycles each, then hold 1
        s_raw = 4'h5;
        tick(2);
        s_raw = 4'h4;
        tick(2);
        check("bounce no early update", s, 4'h4);
        step("bounce settle", 4'h5, 4'h4);

        // Three-cycle glitch on bit3
        s_raw = 4'hD;
        tick(3);
        s_raw = 4'h5;
        tick(10);
        check("glitch ignored", s, 4'h5);

        // Bits 1 and 2 change together
        step("simultaneous", 4'h3, 4'h5);

        // Reset while bit2 is pending at count 2
        s_raw = 4'h7;
        tick(4);
        reset = 1'b0;
        #1;
        check("mid reset s", s, 4'h0);
        check("mid reset s_changed", s_changed, 1'b0);
        tick(3);
        check("mid reset held s", s, 4'h0);
        reset = 1'b1;
        k = cyc + 1;
        expect_update(4'h7, k + 1 + S);
        tick(S + 1);
        check("requalify before window", s, 4'h0);
        tick(1);
        check("requalify after window", s, 4'h7);
        tick(10);

        check("scoreboard drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
